// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// ------------------
// Multi-entry register file with a per-register write-reservation scoreboard.
// Decode/issue reserves a destination register before its producer runs, and
// reads operands together with a busy flag. The writeback stage returns the
// result and releases one reservation. A register can have up to MAX_PENDING
// outstanding writes (WAW). Writebacks to one register arrive in reservation
// order, so the last writeback leaves the youngest value.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   rd0_idx_i    read port 0 index
//   rd0_data_o   read port 0 data (combinational, optionally bypassed)
//   rd0_busy_o   read port 0 register has a pending write
//   rd1_idx_i    read port 1 index
//   rd1_data_o   read port 1 data
//   rd1_busy_o   read port 1 busy flag
//   rsv_i        reserve request for rsv_idx_i
//   rsv_idx_i    register to reserve
//   rsv_full_o   reservation counter of rsv_idx_i is saturated
//   wb_i         writeback valid
//   wb_idx_i     writeback destination
//   wb_data_i    writeback data
//   flush_i      cancel all outstanding reservations, data is kept
//   wb_err_o     registered pulse, previous writeback hit an unreserved register
module regfile_scoreboard #(
    parameter int          LEN_REG      = 32,
    parameter int          NUM_REGS     = 8,
    parameter int          MAX_PENDING  = 3,
    parameter bit          ZERO_REG     = 1'b1,
    parameter bit          BYPASS       = 1'b1,
    parameter logic [LEN_REG-1:0] INITIAL_DATA = {LEN_REG{1'b0}},
    localparam int         LEN_IDX      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int         LEN_CNT      = $clog2(MAX_PENDING + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEN_IDX-1:0] rd0_idx_i,
    output logic [LEN_REG-1:0] rd0_data_o,
    output logic               rd0_busy_o,
    input  logic [LEN_IDX-1:0] rd1_idx_i,
    output logic [LEN_REG-1:0] rd1_data_o,
    output logic               rd1_busy_o,
    input  logic               rsv_i,
    input  logic [LEN_IDX-1:0] rsv_idx_i,
    output logic               rsv_full_o,
    input  logic               wb_i,
    input  logic [LEN_IDX-1:0] wb_idx_i,
    input  logic [LEN_REG-1:0] wb_data_i,
    input  logic               flush_i,
    output logic               wb_err_o
);

    logic [LEN_REG-1:0] data_q [NUM_REGS];
    logic [LEN_REG-1:0] data_d [NUM_REGS];
    logic [LEN_CNT-1:0] cnt_q  [NUM_REGS];
    logic [LEN_CNT-1:0] cnt_d  [NUM_REGS];
    logic               wb_err_q;
    logic               wb_err_d;

    logic               wb_is_zero;
    logic               rsv_is_zero;
    logic               wb_acc;
    logic               rsv_acc;

    // Register 0 is invisible to the scoreboard when it is hardwired to zero,
    // so requests aimed at it are dropped before any other qualification.
    always_comb begin
        wb_is_zero  = ZERO_REG && (wb_idx_i == '0);
        rsv_is_zero = ZERO_REG && (rsv_idx_i == '0);
        rsv_full_o  = !rsv_is_zero && (cnt_q[rsv_idx_i] == LEN_CNT'(MAX_PENDING));
        wb_acc      = wb_i && (cnt_q[wb_idx_i] != '0) && !flush_i && !wb_is_zero;
        // Reserve is judged against the count before this cycle's writeback.
        rsv_acc     = rsv_i && !rsv_full_o && !flush_i && !rsv_is_zero;
        // A writeback nobody reserved is a protocol error; flush and the zero
        // register swallow writebacks silently.
        wb_err_d    = wb_i && (cnt_q[wb_idx_i] == '0) && !flush_i && !wb_is_zero;
    end

    // Next-state for every entry. A reserve and a writeback on the same
    // register cancel out in the counter while the data is still written.
    // Flush clears every counter and wins over both requests.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            data_d[r] = data_q[r];
            cnt_d[r]  = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = '0;
            end else begin
                if (wb_acc && (wb_idx_i == LEN_IDX'(r))) begin
                    data_d[r] = wb_data_i;
                end
                if ((rsv_acc && (rsv_idx_i == LEN_IDX'(r))) &&
                    !(wb_acc && (wb_idx_i == LEN_IDX'(r)))) begin
                    cnt_d[r] = cnt_q[r] + LEN_CNT'(1);
                end else if (!(rsv_acc && (rsv_idx_i == LEN_IDX'(r))) &&
                             (wb_acc && (wb_idx_i == LEN_IDX'(r)))) begin
                    cnt_d[r] = cnt_q[r] - LEN_CNT'(1);
                end
            end
        end
    end

    // State registers; reset drops every reservation immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= INITIAL_DATA;
                cnt_q[r]  <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= data_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err_o = wb_err_q;

    // Read port 0. With bypass, an accepted writeback to the read register is
    // forwarded and busy reflects the count after that writeback; a reserve in
    // the same cycle only shows up after the edge.
    always_comb begin
        rd0_data_o = data_q[rd0_idx_i];
        rd0_busy_o = (cnt_q[rd0_idx_i] != '0);
        if (BYPASS && wb_acc && (wb_idx_i == rd0_idx_i)) begin
            rd0_data_o = wb_data_i;
            rd0_busy_o = (cnt_q[rd0_idx_i] != LEN_CNT'(1));
        end
        if (ZERO_REG && (rd0_idx_i == '0)) begin
            rd0_data_o = '0;
            rd0_busy_o = 1'b0;
        end
    end

    // Read port 1, identical to port 0.
    always_comb begin
        rd1_data_o = data_q[rd1_idx_i];
        rd1_busy_o = (cnt_q[rd1_idx_i] != '0);
        if (BYPASS && wb_acc && (wb_idx_i == rd1_idx_i)) begin
            rd1_data_o = wb_data_i;
            rd1_busy_o = (cnt_q[rd1_idx_i] != LEN_CNT'(1));
        end
        if (ZERO_REG && (rd1_idx_i == '0)) begin
            rd1_data_o = '0;
            rd1_busy_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard with default parameters
// (32-bit data, 8 registers, 3 pending writes, zero register, bypass on).
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [2:0]  rd0_idx_i;
    logic [31:0] rd0_data_o;
    logic        rd0_busy_o;
    logic [2:0]  rd1_idx_i;
    logic [31:0] rd1_data_o;
    logic        rd1_busy_o;
    logic        rsv_i;
    logic [2:0]  rsv_idx_i;
    logic        rsv_full_o;
    logic        wb_i;
    logic [2:0]  wb_idx_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    logic        wb_err_o;

    int compared;
    int mismatched;

    regfile_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .rd0_idx_i  (rd0_idx_i),
        .rd0_data_o (rd0_data_o),
        .rd0_busy_o (rd0_busy_o),
        .rd1_idx_i  (rd1_idx_i),
        .rd1_data_o (rd1_data_o),
        .rd1_busy_o (rd1_busy_o),
        .rsv_i      (rsv_i),
        .rsv_idx_i  (rsv_idx_i),
        .rsv_full_o (rsv_full_o),
        .wb_i       (wb_i),
        .wb_idx_i   (wb_idx_i),
        .wb_data_i  (wb_data_i),
        .flush_i    (flush_i),
        .wb_err_o   (wb_err_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop all requests back to idle.
    task automatic idle();
        rsv_i     = 1'b0;
        wb_i      = 1'b0;
        flush_i   = 1'b0;
        wb_data_i = 32'h0;
    endtask

    // Reset state seen on both ports at r3.
    task automatic test_reset();
        rst = 1'b0;
        idle();
        rd0_idx_i = 3'd3;
        rd1_idx_i = 3'd3;
        rsv_idx_i = 3'd3;
        wb_idx_i  = 3'd0;
        #2;
        compared++; if (rd0_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rd0_data: got %h expected %h", rd0_data_o, 32'h0); end
        compared++; if (rd1_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rd1_data: got %h expected %h", rd1_data_o, 32'h0); end
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd0_busy: got %b expected 0", rd0_busy_o); end
        compared++; if (rd1_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd1_busy: got %b expected 0", rd1_busy_o); end
        compared++; if (rsv_full_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rsv_full: got %b expected 0", rsv_full_o); end
        compared++; if (wb_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wb_err: got %b expected 0", wb_err_o); end
        #6;
        rst = 1'b1;
        tick();
    endtask

    // Reserve r3, then write it back with the read port looking at it.
    task automatic test_bypass();
        rd0_idx_i = 3'd3;
        rd1_idx_i = 3'd3;
        rsv_i = 1'b1; rsv_idx_i = 3'd3;
        tick();
        rsv_i = 1'b0;
        compared++; if (rd0_busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL bypass_reserved_busy: got %b expected 1", rd0_busy_o); end
        wb_i = 1'b1; wb_idx_i = 3'd3; wb_data_i = 32'hDEADBEEF;
        #1;
        compared++; if (rd0_data_o !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL bypass_rd0_data: got %h expected %h", rd0_data_o, 32'hDEADBEEF); end
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL bypass_rd0_busy: got %b expected 0", rd0_busy_o); end
        compared++; if (rd1_data_o !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL bypass_rd1_data: got %h expected %h", rd1_data_o, 32'hDEADBEEF); end
        tick();
        idle();
        #1;
        compared++; if (rd0_data_o !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL wb_stored_data: got %h expected %h", rd0_data_o, 32'hDEADBEEF); end
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL wb_stored_busy: got %b expected 0", rd0_busy_o); end
        compared++; if (wb_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL bypass_no_err: got %b expected 0", wb_err_o); end
    endtask

    // Three reservations saturate r5; a fourth is refused. Three writebacks
    // then retire it, so busy must clear exactly on the third one.
    task automatic test_saturation();
        logic [31:0] wb_vals [3];
        wb_vals[0] = 32'h1; wb_vals[1] = 32'h2; wb_vals[2] = 32'h3;
        rd0_idx_i = 3'd5;
        rsv_idx_i = 3'd5;
        for (int i = 0; i < 3; i++) begin
            rsv_i = 1'b1;
            #1;
            compared++; if (rsv_full_o !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_not_full_%0d: got %b expected 0", i, rsv_full_o); end
            tick();
        end
        #1;
        compared++; if (rsv_full_o !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_full: got %b expected 1", rsv_full_o); end
        tick();
        rsv_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_i = 1'b1; wb_idx_i = 3'd5; wb_data_i = wb_vals[i];
            tick();
            wb_i = 1'b0;
            #1;
            compared++; if (rd0_data_o !== wb_vals[i]) begin mismatched++; $display("[TB] FAIL sat_data_%0d: got %h expected %h", i, rd0_data_o, wb_vals[i]); end
            compared++; if (rd0_busy_o !== (i != 2)) begin mismatched++; $display("[TB] FAIL sat_busy_%0d: got %b expected %b", i, rd0_busy_o, (i != 2)); end
        end
        compared++; if (rsv_full_o !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_drained_full: got %b expected 0", rsv_full_o); end
        compared++; if (wb_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_no_err: got %b expected 0", wb_err_o); end
    endtask

    // Reserve and writeback on r2 in one cycle while one write is pending.
    task automatic test_same_cycle();
        rd0_idx_i = 3'd2;
        rsv_i = 1'b1; rsv_idx_i = 3'd2;
        tick();
        rsv_i = 1'b1; rsv_idx_i = 3'd2;
        wb_i = 1'b1; wb_idx_i = 3'd2; wb_data_i = 32'hA5A5A5A5;
        #1;
        compared++; if (rd0_data_o !== 32'hA5A5A5A5) begin mismatched++; $display("[TB] FAIL same_bypass_data: got %h expected %h", rd0_data_o, 32'hA5A5A5A5); end
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL same_bypass_busy: got %b expected 0", rd0_busy_o); end
        tick();
        idle();
        #1;
        compared++; if (rd0_data_o !== 32'hA5A5A5A5) begin mismatched++; $display("[TB] FAIL same_data: got %h expected %h", rd0_data_o, 32'hA5A5A5A5); end
        compared++; if (rd0_busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL same_busy: got %b expected 1", rd0_busy_o); end
        wb_i = 1'b1; wb_idx_i = 3'd2; wb_data_i = 32'h12345678;
        tick();
        idle();
        #1;
        compared++; if (rd0_data_o !== 32'h12345678) begin mismatched++; $display("[TB] FAIL same_second_data: got %h expected %h", rd0_data_o, 32'h12345678); end
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL same_second_busy: got %b expected 0", rd0_busy_o); end
    endtask

    // Writeback to unreserved r6 flags an error for exactly one cycle.
    task automatic test_wb_error();
        rd0_idx_i = 3'd6;
        wb_i = 1'b1; wb_idx_i = 3'd6; wb_data_i = 32'hCAFEF00D;
        #1;
        compared++; if (rd0_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL err_no_bypass: got %h expected %h", rd0_data_o, 32'h0); end
        tick();
        idle();
        #1;
        compared++; if (wb_err_o !== 1'b1) begin mismatched++; $display("[TB] FAIL err_pulse: got %b expected 1", wb_err_o); end
        compared++; if (rd0_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL err_data_kept: got %h expected %h", rd0_data_o, 32'h0); end
        tick();
        compared++; if (wb_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL err_pulse_end: got %b expected 0", wb_err_o); end
    endtask

    // Register 0 ignores reserve and writeback and never raises an error.
    task automatic test_zero_reg();
        rd0_idx_i = 3'd0;
        rd1_idx_i = 3'd0;
        rsv_i = 1'b1; rsv_idx_i = 3'd0;
        wb_i = 1'b1; wb_idx_i = 3'd0; wb_data_i = 32'hFFFFFFFF;
        #1;
        compared++; if (rd0_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL zero_bypass_data: got %h expected %h", rd0_data_o, 32'h0); end
        compared++; if (rsv_full_o !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_rsv_full: got %b expected 0", rsv_full_o); end
        tick();
        rsv_i = 1'b0;
        wb_data_i = 32'h00000077;
        #1;
        compared++; if (rd0_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL zero_data: got %h expected %h", rd0_data_o, 32'h0); end
        compared++; if (rd1_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_busy: got %b expected 0", rd1_busy_o); end
        compared++; if (wb_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_err_first: got %b expected 0", wb_err_o); end
        tick();
        idle();
        compared++; if (wb_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_err_second: got %b expected 0", wb_err_o); end
    endtask

    // Flush with r1 and r4 reserved and a writeback to r1 in the same cycle.
    task automatic test_flush();
        rd0_idx_i = 3'd1;
        rd1_idx_i = 3'd4;
        rsv_i = 1'b1; rsv_idx_i = 3'd1;
        tick();
        rsv_i = 1'b0;
        wb_i = 1'b1; wb_idx_i = 3'd1; wb_data_i = 32'h00000011;
        tick();
        idle();
        rsv_i = 1'b1; rsv_idx_i = 3'd1;
        tick();
        rsv_idx_i = 3'd4;
        tick();
        rsv_i = 1'b0;
        compared++; if (rd0_busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_pre_busy_r1: got %b expected 1", rd0_busy_o); end
        compared++; if (rd1_busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_pre_busy_r4: got %b expected 1", rd1_busy_o); end
        flush_i = 1'b1;
        rsv_i = 1'b1; rsv_idx_i = 3'd4;
        wb_i = 1'b1; wb_idx_i = 3'd1; wb_data_i = 32'h00000055;
        #1;
        compared++; if (rd0_data_o !== 32'h00000011) begin mismatched++; $display("[TB] FAIL flush_no_bypass: got %h expected %h", rd0_data_o, 32'h00000011); end
        tick();
        idle();
        #1;
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_busy_r1: got %b expected 0", rd0_busy_o); end
        compared++; if (rd1_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_busy_r4: got %b expected 0", rd1_busy_o); end
        compared++; if (rd0_data_o !== 32'h00000011) begin mismatched++; $display("[TB] FAIL flush_data_r1: got %h expected %h", rd0_data_o, 32'h00000011); end
        compared++; if (wb_err_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_err: got %b expected 0", wb_err_o); end
    endtask

    // Reset between clock edges clears counters and data at once.
    task automatic test_async_reset();
        rd0_idx_i = 3'd7;
        rd1_idx_i = 3'd3;
        rsv_i = 1'b1; rsv_idx_i = 3'd7;
        tick();
        rsv_idx_i = 3'd3;
        tick();
        rsv_i = 1'b0;
        compared++; if (rd0_busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL areset_pre_busy: got %b expected 1", rd0_busy_o); end
        #2;
        rst = 1'b0;
        #1;
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_busy_r7: got %b expected 0", rd0_busy_o); end
        compared++; if (rd1_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_busy_r3: got %b expected 0", rd1_busy_o); end
        compared++; if (rd1_data_o !== 32'h0) begin mismatched++; $display("[TB] FAIL areset_data_r3: got %h expected %h", rd1_data_o, 32'h0); end
        #2;
        rst = 1'b1;
        tick();
        compared++; if (rd0_busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL areset_after_busy: got %b expected 0", rd0_busy_o); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_bypass();
        test_saturation();
        test_same_cycle();
        test_wb_error();
        test_zero_reg();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
